// File: rtl/run_monitor.sv
// run_monitor: run controller for Wrapper. It stretches the CPU reset, counts RUN cycles and retired instructions,
// and ends a run on halt, PC quiescence or watchdog. Define RUN_MONITOR_HALT_DETECT_EN to build in PC-quiescence detection.
module run_monitor #(
    parameter int ADDR_W      = 12,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 4,
    parameter int MAX_CYCLES  = 400,
    parameter int HALT_STABLE = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic              halt_in,
    input  logic              commit_valid,
    input  logic [ADDR_W-1:0] pc,
    output logic              cpu_reset_n,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    localparam int                HOLD_W    = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic              WD_EN     = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0]  WD_LAST   = CNT_W'(MAX_CYCLES - 1);

    state_t            r_state;
    logic [HOLD_W-1:0] r_hold;
    logic              w_pc_halt;
    logic              w_timeout_hit;
    logic [CNT_W-1:0]  w_cycle_next;
    logic [CNT_W-1:0]  w_instr_next;

    // Saturating increments and watchdog compare on the current counter values
    always_comb begin
        w_cycle_next  = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
        w_instr_next  = (&instr_count) ? instr_count : instr_count + CNT_W'(1);
        w_timeout_hit = WD_EN && (cycle_count == WD_LAST);
    end

`ifdef RUN_MONITOR_HALT_DETECT_EN
    localparam int               STB_W    = $clog2(HALT_STABLE);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(HALT_STABLE - 2);

    logic [ADDR_W-1:0] r_pc_hist;
    logic [STB_W-1:0]  r_stable;
    logic              w_pc_same;

    // Halt fires on the sample that makes HALT_STABLE equal PCs in a row
    always_comb begin
        w_pc_same = (pc == r_pc_hist);
        w_pc_halt = w_pc_same && (r_stable == STB_LAST);
    end

    // PC history and stable-run counter; the counter is held at zero outside RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_hist <= '0;
            r_stable  <= '0;
        end else if (r_state == S_RUN) begin
            r_pc_hist <= pc;
            r_stable  <= w_pc_same ? r_stable + STB_W'(1) : '0;
        end else begin
            r_stable  <= '0;
        end
    end
`else
    logic w_pc_unused;

    // No quiescence detection in this build
    always_comb begin
        w_pc_halt   = 1'b0;
        w_pc_unused = (^pc) ^ (HALT_STABLE > 1);
    end
`endif

    // Run-control FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            cpu_reset_n <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_HOLD;
                        r_hold      <= '0;
                        cycle_count <= '0;
                        instr_count <= '0;
                    end
                end
                S_HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state     <= S_RUN;
                        cpu_reset_n <= 1'b1;
                        running     <= 1'b1;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    cycle_count <= w_cycle_next;
                    if (commit_valid) begin
                        instr_count <= w_instr_next;
                    end
                    // A halt outranks a watchdog expiry on the same edge
                    if (halt_in || w_pc_halt) begin
                        r_state <= S_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (w_timeout_hit) begin
                        r_state <= S_TIMEOUT;
                        running <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                S_DONE, S_TIMEOUT: begin
                    if (clear) begin
                        r_state     <= S_IDLE;
                        cpu_reset_n <= 1'b0;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        instr_count <= '0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    cpu_reset_n <= 1'b0;
                    running     <= 1'b0;
                    done        <= 1'b0;
                    timeout     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: vector table, directed corner sequences, and randomized
// stimulus compared against a behavioural reference model.
module tb_run_monitor;

    localparam int ADDR_W      = 12;
    localparam int CNT_W       = 32;
    localparam int RST_CYCLES  = 4;
    localparam int MAX_CYCLES  = 400;
    localparam int HALT_STABLE = 8;
`ifdef RUN_MONITOR_HALT_DETECT_EN
    localparam bit PC_DET = 1'b1;
`else
    localparam bit PC_DET = 1'b0;
`endif

    localparam int M_IDLE = 0, M_HOLD = 1, M_RUN = 2, M_DONE = 3, M_TO = 4;

    logic              clk;
    logic              reset_i;
    logic              start_i, clear_i, halt_i, commit_i;
    logic [ADDR_W-1:0] pc_i;
    logic              cpu_reset_n, running, done, timeout;
    logic [CNT_W-1:0]  cycle_count, instr_count;

    run_monitor #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES),
        .MAX_CYCLES(MAX_CYCLES), .HALT_STABLE(HALT_STABLE)
    ) dut (
        .clk(clk), .reset(reset_i), .start(start_i), .clear(clear_i),
        .halt_in(halt_i), .commit_valid(commit_i), .pc(pc_i),
        .cpu_reset_n(cpu_reset_n), .running(running), .done(done), .timeout(timeout),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit pc_auto  = 1'b1;

    // Reference model
    int              m_ph, m_hold_left, m_eq_len;
    longint          m_cyc, m_ins;
    logic [ADDR_W-1:0] m_prev;
    longint          cnt_max;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = M_IDLE; m_hold_left = 0; m_eq_len = 0;
        m_cyc = 0; m_ins = 0; m_prev = '0;
    endtask

    task automatic model_step();
        bit pc_quiet;
        pc_quiet = 1'b0;
        case (m_ph)
            M_IDLE: if (start_i) begin
                m_ph = M_HOLD; m_hold_left = RST_CYCLES; m_cyc = 0; m_ins = 0;
            end
            M_HOLD: begin
                m_hold_left--;
                if (m_hold_left == 0) begin m_ph = M_RUN; m_eq_len = 1; end
            end
            M_RUN: begin
                if (m_cyc < cnt_max) m_cyc++;
                if (commit_i && m_ins < cnt_max) m_ins++;
                // m_eq_len = length of the current run of equal PC samples, history included
                m_eq_len = (pc_i == m_prev) ? m_eq_len + 1 : 1;
                m_prev   = pc_i;
                pc_quiet = PC_DET && (m_eq_len >= HALT_STABLE);
                if (halt_i || pc_quiet) m_ph = M_DONE;
                else if (MAX_CYCLES != 0 && m_cyc == MAX_CYCLES) m_ph = M_TO;
            end
            default: if (clear_i) begin m_ph = M_IDLE; m_cyc = 0; m_ins = 0; end
        endcase
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_rstn"},    64'(cpu_reset_n), 64'(m_ph >= M_RUN));
        check({tag, "_running"}, 64'(running),     64'(m_ph == M_RUN));
        check({tag, "_done"},    64'(done),        64'(m_ph == M_DONE));
        check({tag, "_timeout"}, 64'(timeout),     64'(m_ph == M_TO));
        check({tag, "_cycles"},  64'(cycle_count), 64'(m_cyc));
        check({tag, "_instrs"},  64'(instr_count), 64'(m_ins));
    endtask

    // One clock: model follows the edge, outputs sampled on the falling edge
    task automatic tick(input bit cmp, input string tag);
        @(posedge clk);
        if (reset_i) model_step();
        else model_reset();
        @(negedge clk);
        if (cmp) compare_model(tag);
        if (pc_auto) pc_i = pc_i + ADDR_W'(1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b0;
        start_i = 1'b0; clear_i = 1'b0; halt_i = 1'b0; commit_i = 1'b0;
        model_reset();
        @(negedge clk);
        reset_i = 1'b1;
    endtask

    task automatic start_run();
        start_i = 1'b1;
        tick(1'b1, "start");
        start_i = 1'b0;
        for (int h = 0; h < RST_CYCLES; h++) tick(1'b1, "hold");
    endtask

    task automatic clear_run();
        clear_i = 1'b1;
        tick(1'b1, "clear");
        clear_i = 1'b0;
    endtask

    typedef struct {
        bit start, clear, halt, commit;
        bit e_rstn, e_run, e_done, e_to;
        int e_cyc, e_ins;
    } vec_t;
    vec_t tbl[12];

    int wd_edges, d_edges, pc_hold;

    initial begin
        cnt_max = (64'd1 << CNT_W) - 64'd1;
        tbl[0]  = '{0,0,0,0, 0,0,0,0, 0,0};
        tbl[1]  = '{1,0,0,0, 0,0,0,0, 0,0};
        tbl[2]  = '{0,0,0,0, 0,0,0,0, 0,0};
        tbl[3]  = '{0,0,0,0, 0,0,0,0, 0,0};
        tbl[4]  = '{0,0,0,0, 0,0,0,0, 0,0};
        tbl[5]  = '{0,0,0,0, 1,1,0,0, 0,0};
        tbl[6]  = '{0,0,0,1, 1,1,0,0, 1,1};
        tbl[7]  = '{0,0,0,0, 1,1,0,0, 2,1};
        tbl[8]  = '{0,0,1,1, 1,0,1,0, 3,2};
        tbl[9]  = '{1,0,0,0, 1,0,1,0, 3,2};
        tbl[10] = '{0,1,0,0, 0,0,0,0, 0,0};
        tbl[11] = '{1,0,0,0, 0,0,0,0, 0,0};

        reset_i = 1'b0;
        start_i = 1'b0; clear_i = 1'b0; halt_i = 1'b0; commit_i = 1'b0;
        pc_i = '0;
        model_reset();
        #2;
        compare_model("reset");
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b1;

        // Vector table: start pulse, reset stretch, commits, halt, ignored start, clear, restart
        for (int i = 0; i < 12; i++) begin
            start_i = tbl[i].start; clear_i = tbl[i].clear;
            halt_i  = tbl[i].halt;  commit_i = tbl[i].commit;
            tick(1'b0, "tbl");
            check($sformatf("row%0d_rstn", i),    64'(cpu_reset_n), 64'(tbl[i].e_rstn));
            check($sformatf("row%0d_running", i), 64'(running),     64'(tbl[i].e_run));
            check($sformatf("row%0d_done", i),    64'(done),        64'(tbl[i].e_done));
            check($sformatf("row%0d_timeout", i), 64'(timeout),     64'(tbl[i].e_to));
            check($sformatf("row%0d_cycles", i),  64'(cycle_count), 64'(tbl[i].e_cyc));
            check($sformatf("row%0d_instrs", i),  64'(instr_count), 64'(tbl[i].e_ins));
        end
        start_i = 1'b0; clear_i = 1'b0; halt_i = 1'b0; commit_i = 1'b0;

        // Watchdog
        do_reset();
        start_run();
        wd_edges = -1;
        for (int i = 1; i <= MAX_CYCLES + 50; i++) begin
            tick(1'b1, "wd");
            if (timeout === 1'b1) begin wd_edges = i; break; end
        end
        check("wd_edges", 64'(wd_edges), 64'(MAX_CYCLES));
        check("wd_timeout", 64'(timeout), 64'd1);
        check("wd_running", 64'(running), 64'd0);
        check("wd_cycles", 64'(cycle_count), 64'(MAX_CYCLES));
        check("wd_instrs", 64'(instr_count), 64'd0);
        for (int i = 0; i < 50; i++) tick(1'b1, "wd_hold");
        check("wd_hold_cycles", 64'(cycle_count), 64'(MAX_CYCLES));
        check("wd_hold_timeout", 64'(timeout), 64'd1);

        // External halt after 10 commits, then an ignored start
        clear_run();
        check("clr_cycles", 64'(cycle_count), 64'd0);
        check("clr_timeout", 64'(timeout), 64'd0);
        start_run();
        for (int k = 1; k <= 20; k++) begin
            commit_i = (k <= 10);
            halt_i   = (k == 20);
            tick(1'b1, "halt");
        end
        commit_i = 1'b0; halt_i = 1'b0;
        check("halt_done", 64'(done), 64'd1);
        check("halt_running", 64'(running), 64'd0);
        check("halt_cycles", 64'(cycle_count), 64'd20);
        check("halt_instrs", 64'(instr_count), 64'd10);
        start_i = 1'b1;
        tick(1'b1, "ign_start");
        start_i = 1'b0;
        check("ign_start_done", 64'(done), 64'd1);
        check("ign_start_cycles", 64'(cycle_count), 64'd20);

        // Halt on the watchdog edge
        clear_run();
        start_run();
        for (int k = 1; k <= MAX_CYCLES; k++) begin
            halt_i = (k == MAX_CYCLES);
            tick(1'b1, "tie");
        end
        halt_i = 1'b0;
        check("tie_done", 64'(done), 64'd1);
        check("tie_timeout", 64'(timeout), 64'd0);
        check("tie_cycles", 64'(cycle_count), 64'(MAX_CYCLES));

        // PC climbs to 0x010 and then holds
        clear_run();
        start_run();
        pc_auto = 1'b0;
        d_edges = -1;
        for (int k = 1; k <= MAX_CYCLES + 10; k++) begin
            pc_i = (k < 16) ? ADDR_W'(k) : ADDR_W'(16);
            tick(1'b1, "quiet");
            if (done === 1'b1 || timeout === 1'b1) begin d_edges = k; break; end
        end
        pc_auto = 1'b1;
`ifdef RUN_MONITOR_HALT_DETECT_EN
        check("quiet_edges", 64'(d_edges), 64'd23);
        check("quiet_done", 64'(done), 64'd1);
        check("quiet_cycles", 64'(cycle_count), 64'd23);
`else
        check("quiet_edges", 64'(d_edges), 64'(MAX_CYCLES));
        check("quiet_timeout", 64'(timeout), 64'd1);
        check("quiet_cycles", 64'(cycle_count), 64'(MAX_CYCLES));
`endif

        // Clear, restart, then asynchronous reset at RUN cycle 37
        clear_run();
        check("clr2_rstn", 64'(cpu_reset_n), 64'd0);
        check("clr2_done", 64'(done | timeout), 64'd0);
        check("clr2_instrs", 64'(instr_count), 64'd0);
        start_i = 1'b1;
        tick(1'b1, "re_start");
        start_i = 1'b0;
        check("re_start_rstn", 64'(cpu_reset_n), 64'd0);
        for (int h = 1; h <= RST_CYCLES; h++) begin
            tick(1'b1, "re_hold");
            check($sformatf("re_hold%0d_rstn", h), 64'(cpu_reset_n), 64'(h == RST_CYCLES));
            check($sformatf("re_hold%0d_running", h), 64'(running), 64'(h == RST_CYCLES));
        end
        for (int k = 1; k <= 37; k++) begin
            commit_i = k[0];
            tick(1'b1, "pre_areset");
        end
        commit_i = 1'b0;
        #2 reset_i = 1'b0;
        #1;
        check("areset_rstn", 64'(cpu_reset_n), 64'd0);
        check("areset_running", 64'(running), 64'd0);
        check("areset_cycles", 64'(cycle_count), 64'd0);
        check("areset_instrs", 64'(instr_count), 64'd0);
        model_reset();
        @(negedge clk);
        reset_i = 1'b1;

        // Randomized traffic against the model
        pc_auto = 1'b0;
        pc_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            start_i  = ($urandom_range(0, 7) == 0);
            clear_i  = ($urandom_range(0, 15) == 0);
            halt_i   = ($urandom_range(0, 299) == 0);
            commit_i = $urandom_range(0, 1);
            if (pc_hold > 0) pc_hold--;
            else begin
                pc_i = pc_i + ADDR_W'($urandom_range(1, 3));
                if ($urandom_range(0, 19) == 0) pc_hold = $urandom_range(2, 12);
            end
            if ($urandom_range(0, 799) == 0) begin
                #2 reset_i = 1'b0;
                model_reset();
                #1 compare_model("rnd_areset");
                @(negedge clk);
                reset_i = 1'b1;
            end
            tick(1'b1, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
